spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  Command/register controller behind the SPI slave core. Decodes a command byte
//  (R/W + address), then streams data bytes into or out of an internal register
//  file with address auto-increment. Feeds data_to_send on each data_needed
//  request. Exposes the register file flat to fabric, e.g. for LEDs and config.
// PARAMETERS
//  NUM_REGS     8      number of 8-bit registers (2..128)
//  ADDR_W       3      address width, = clog2(NUM_REGS)
//  STATUS_BYTE  8'hA5  byte returned to master during the command byte
// PORTS
//  clk            in   1            system clock; all logic on posedge
//  rst_n          in   1            asynchronous reset, active low
//  ssel           in   1            SPI select, active low, raw pin (synced here)
//  byte_received  in   1            1-clk pulse from slave: received_data valid
//  received_data  in   8            byte shifted in from master
//  data_needed    in   1            1-clk pulse from slave: load next tx byte
//  data_to_send   out  8            tx byte to slave, registered
//  regs_flat      out  NUM_REGS*8   register file, reg[i] at [8i+7:8i]
//  wr_strobe      out  1            1-clk pulse when a register was written
//  wr_addr        out  ADDR_W       address of the last write
//  frame_err      out  1            sticky: bad address seen this frame
//  busy           out  1            high while a frame is active
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, all regs 0, data_to_send=STATUS_BYTE,
//   wr_strobe=0, wr_addr=0, frame_err=0, busy=0, addr ptr=0, ssel sync flops=1.
//  ssel passes a 2-FF synchronizer (ssel_s). Frame active = ssel_s low.
//  States: IDLE, CMD, WR, RD, SKIP.
//   IDLE: busy=0. ssel_s falling -> CMD, frame_err cleared, data_to_send=STATUS_BYTE.
//   CMD: on byte_received decode received_data: bit7=1 write, bit7=0 read,
//    bits6:0 = address. addr >= NUM_REGS -> SKIP, frame_err=1.
//    Otherwise ptr=addr[ADDR_W-1:0], then -> WR or RD.
//    data_needed in CMD -> data_to_send=STATUS_BYTE.
//   WR: each byte_received -> reg[ptr]=received_data, wr_strobe=1 next clk,
//    wr_addr=ptr, ptr++. data_needed -> data_to_send=STATUS_BYTE.
//   RD: each data_needed -> data_to_send=reg[ptr], ptr++. byte_received ignored.
//   SKIP: writes discarded. data_needed -> data_to_send=8'h00.
//  ptr wraps NUM_REGS-1 -> 0 (not power-of-2 safe: explicit compare).
//  ssel_s high in any state -> IDLE next clk. Partial state is discarded;
//   completed register writes persist. frame_err stays until the next frame start.
//  byte_received/data_needed while IDLE: ignored.
//  Simultaneous byte_received (read cmd) + data_needed in CMD: decode wins and
//   data_to_send=reg[addr] (bypass), ptr=addr+1 (wrapped), -> RD.
//   With a write cmd: data_to_send=STATUS_BYTE.
//  Latency: data_to_send valid 1 clk after data_needed. reg write visible on
//   regs_flat 1 clk after byte_received.
//  wr_strobe is never asserted outside WR. One write per byte_received pulse.
// TESTING
//  1 write burst: ssel low, bytes 0x81,0x55,0xAA -> reg1=0x55, reg2=0xAA,
//    two wr_strobe pulses with wr_addr 1 then 2; tx byte during cmd = 0xA5.
//  2 read wrap: regs preset 0..7=0x10..0x17, cmd 0x07, 3 data_needed ->
//    tx 0x17,0x10,0x11.
//  3 bad addr: cmd 0x88 (NUM_REGS=8), data 0xFF -> no reg change, frame_err=1,
//    reads return 0x00; next frame start clears frame_err.
//  4 abort: ssel high after cmd 0x83 with no data -> IDLE, busy=0, regs unchanged;
//    next frame decodes normally.
//  5 simultaneous: byte_received(0x02)+data_needed same clk -> data_to_send=reg2
//    next clk, following data_needed gives reg3.
//  6 async reset mid-WR burst -> all outputs at reset values without a clk edge.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind an SPI slave core: decodes a R/W + address
// command byte, then streams data bytes into or out of a flop-based register file.
module spi_reg_ctrl #(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_W      = 3,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ssel,
    input  logic                    byte_received,
    input  logic [7:0]              received_data,
    input  logic                    data_needed,
    output logic [7:0]              data_to_send,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    wr_strobe,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic                    frame_err,
    output logic                    busy
);

    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_SKIP
    } state_t;

    state_t              state_reg, state_next;

    logic                ssel_meta_reg, ssel_s_reg, ssel_d_reg;
    logic                frame_start;

    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic                ptr_load;
    logic [7:0]          tx_reg, tx_next;
    logic                tx_load;
    logic                wr_en;
    logic                wr_strobe_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic                err_reg, err_set, err_clr;

    logic [7:0]          reg_file [NUM_REGS];

    logic                cmd_is_wr;
    logic                cmd_addr_ok;
    logic [ADDR_W-1:0]   cmd_addr;

    // Explicit compare so the wrap also works for non power-of-two register counts.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // ssel synchronizer; the extra stage gives a clean falling-edge detect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_meta_reg <= 1'b1;
            ssel_s_reg    <= 1'b1;
            ssel_d_reg    <= 1'b1;
        end else begin
            ssel_meta_reg <= ssel;
            ssel_s_reg    <= ssel_meta_reg;
            ssel_d_reg    <= ssel_s_reg;
        end
    end

    assign frame_start = ssel_d_reg & ~ssel_s_reg;

    assign cmd_is_wr   = received_data[7];
    assign cmd_addr_ok = {1'b0, received_data[6:0]} < NUM_REGS_B;
    assign cmd_addr    = received_data[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (ssel_s_reg) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_start) begin
                        state_next = S_CMD;
                    end
                end
                S_CMD: begin
                    if (byte_received) begin
                        if (!cmd_addr_ok) begin
                            state_next = S_SKIP;
                        end else if (cmd_is_wr) begin
                            state_next = S_WR;
                        end else begin
                            state_next = S_RD;
                        end
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        wr_en    = 1'b0;
        ptr_load = 1'b0;
        ptr_next = ptr_reg;
        tx_load  = 1'b0;
        tx_next  = tx_reg;
        err_set  = 1'b0;
        err_clr  = 1'b0;

        if (!ssel_s_reg) begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_start) begin
                        tx_load = 1'b1;
                        tx_next = STATUS_BYTE;
                        err_clr = 1'b1;
                    end
                end
                S_CMD: begin
                    if (data_needed) begin
                        tx_load = 1'b1;
                        tx_next = STATUS_BYTE;
                    end
                    if (byte_received) begin
                        if (!cmd_addr_ok) begin
                            err_set = 1'b1;
                        end else begin
                            ptr_load = 1'b1;
                            ptr_next = cmd_addr;
                            // Read decode coinciding with a tx request: bypass the
                            // addressed register straight out and step past it.
                            if (!cmd_is_wr && data_needed) begin
                                tx_next  = reg_file[cmd_addr];
                                ptr_next = ptr_inc(cmd_addr);
                            end
                        end
                    end
                end
                S_WR: begin
                    if (byte_received) begin
                        wr_en    = 1'b1;
                        ptr_load = 1'b1;
                        ptr_next = ptr_inc(ptr_reg);
                    end
                    if (data_needed) begin
                        tx_load = 1'b1;
                        tx_next = STATUS_BYTE;
                    end
                end
                S_RD: begin
                    if (data_needed) begin
                        tx_load  = 1'b1;
                        tx_next  = reg_file[ptr_reg];
                        ptr_load = 1'b1;
                        ptr_next = ptr_inc(ptr_reg);
                    end
                end
                S_SKIP: begin
                    if (data_needed) begin
                        tx_load = 1'b1;
                        tx_next = 8'h00;
                    end
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointer, tx byte, write strobe and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            tx_reg        <= STATUS_BYTE;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (ptr_load) begin
                ptr_reg <= ptr_next;
            end
            if (tx_load) begin
                tx_reg <= tx_next;
            end
            wr_strobe_reg <= wr_en;
            if (wr_en) begin
                wr_addr_reg <= ptr_reg;
            end
            if (err_clr) begin
                err_reg <= 1'b0;
            end else if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file: one flop byte per entry so reset clears everything.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= 8'h00;
                end else if (wr_en && (ptr_reg == ADDR_W'(gi))) begin
                    data_reg <= received_data;
                end
            end

            assign reg_file[gi]          = data_reg;
            assign regs_flat[gi*8 +: 8]  = data_reg;
        end
    endgenerate

    assign data_to_send = tx_reg;
    assign wr_strobe    = wr_strobe_reg;
    assign wr_addr      = wr_addr_reg;
    assign frame_err    = err_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios then random frames, all checked
// against a frame-level reference model of the register controller.
module tb_spi_reg_ctrl;

    localparam int         N  = 8;
    localparam logic [7:0] ST = 8'hA5;

    localparam int M_IDLE = 0;
    localparam int M_CMD  = 1;
    localparam int M_WR   = 2;
    localparam int M_RD   = 3;
    localparam int M_SKIP = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           ssel = 1'b1;
    logic           byte_received = 1'b0;
    logic [7:0]     received_data = 8'h00;
    logic           data_needed = 1'b0;
    logic [7:0]     data_to_send;
    logic [N*8-1:0] regs_flat;
    logic           wr_strobe;
    logic [2:0]     wr_addr;
    logic           frame_err;
    logic           busy;

    spi_reg_ctrl #(.NUM_REGS(N), .ADDR_W(3), .STATUS_BYTE(ST)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ssel          (ssel),
        .byte_received (byte_received),
        .received_data (received_data),
        .data_needed   (data_needed),
        .data_to_send  (data_to_send),
        .regs_flat     (regs_flat),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_regs [N];
    int         m_ptr;
    int         m_mode;
    bit         m_err;
    logic [7:0] m_tx;
    int         m_wr_addr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_reg%0d", tag, i), regs_flat[i*8 +: 8], m_regs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_ptr = 0; m_mode = M_IDLE; m_err = 0; m_tx = ST; m_wr_addr = 0;
    endtask

    task automatic model_decode(input logic [7:0] b);
        int a;
        a = int'(b[6:0]);
        if (a >= N) begin
            m_mode = M_SKIP;
            m_err  = 1;
        end else begin
            m_ptr  = a;
            m_mode = b[7] ? M_WR : M_RD;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_tx"},    data_to_send, m_tx);
        check({tag, "_err"},   frame_err,    m_err);
        check({tag, "_busy"},  busy,         m_mode != M_IDLE);
        check({tag, "_waddr"}, wr_addr,      m_wr_addr);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_strobe;
        @(negedge clk);
        received_data = b;
        byte_received = 1'b1;
        @(negedge clk);
        byte_received = 1'b0;
        exp_strobe = 0;
        if (m_mode == M_CMD) begin
            model_decode(b);
        end else if (m_mode == M_WR) begin
            m_regs[m_ptr] = b;
            m_wr_addr     = m_ptr;
            m_ptr         = (m_ptr + 1) % N;
            exp_strobe    = 1;
        end
        check("byte_strobe", wr_strobe, exp_strobe);
        check_outputs("byte");
        check_regs("byte");
        $display("byte rx=%02h mode=%0d strobe=%0b waddr=%0d", b, m_mode, wr_strobe, wr_addr);
    endtask

    task automatic need_byte();
        @(negedge clk);
        data_needed = 1'b1;
        @(negedge clk);
        data_needed = 1'b0;
        case (m_mode)
            M_CMD, M_WR: m_tx = ST;
            M_RD: begin
                m_tx  = m_regs[m_ptr];
                m_ptr = (m_ptr + 1) % N;
            end
            M_SKIP: m_tx = 8'h00;
            default: m_tx = m_tx;
        endcase
        check("need_strobe", wr_strobe, 1'b0);
        check_outputs("need");
        $display("need tx=%02h mode=%0d", data_to_send, m_mode);
    endtask

    // Command byte and tx request in the same clock (only used while in CMD).
    task automatic both_cmd(input logic [7:0] b);
        @(negedge clk);
        received_data = b;
        byte_received = 1'b1;
        data_needed   = 1'b1;
        @(negedge clk);
        byte_received = 1'b0;
        data_needed   = 1'b0;
        model_decode(b);
        if (m_mode == M_RD) begin
            m_tx  = m_regs[m_ptr];
            m_ptr = (m_ptr + 1) % N;
        end else begin
            m_tx = ST;
        end
        check("both_strobe", wr_strobe, 1'b0);
        check_outputs("both");
        $display("both rx=%02h tx=%02h mode=%0d", b, data_to_send, m_mode);
    endtask

    task automatic frame_begin();
        ssel = 1'b0;
        repeat (4) @(negedge clk);
        m_mode = M_CMD;
        m_err  = 0;
        m_tx   = ST;
        check_outputs("start");
        $display("frame start busy=%0b", busy);
    endtask

    task automatic frame_end();
        ssel = 1'b1;
        repeat (4) @(negedge clk);
        m_mode = M_IDLE;
        check_outputs("end");
        check_regs("end");
        $display("frame end err=%0b", frame_err);
    endtask

    initial begin
        model_reset();
        // Async reset with no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        check_outputs("rst");
        check("rst_strobe", wr_strobe, 1'b0);
        check_regs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write burst
        frame_begin();
        need_byte();
        check("t1_status", data_to_send, 8'hA5);
        send_byte(8'h81);
        send_byte(8'h55);
        check("t1_waddr1", wr_addr, 3'd1);
        send_byte(8'hAA);
        check("t1_waddr2", wr_addr, 3'd2);
        frame_end();
        check("t1_reg1", regs_flat[15:8], 8'h55);
        check("t1_reg2", regs_flat[23:16], 8'hAA);

        // 2: read wrap after presetting all registers
        frame_begin();
        send_byte(8'h80);
        for (int i = 0; i < N; i++) send_byte(8'h10 + 8'(i));
        frame_end();
        frame_begin();
        send_byte(8'h07);
        need_byte(); check("t2_a", data_to_send, 8'h17);
        need_byte(); check("t2_b", data_to_send, 8'h10);
        need_byte(); check("t2_c", data_to_send, 8'h11);
        frame_end();

        // 3: bad address
        frame_begin();
        send_byte(8'h88);
        send_byte(8'hFF);
        need_byte(); check("t3_rd0", data_to_send, 8'h00);
        check("t3_err", frame_err, 1'b1);
        frame_end();
        check("t3_err_sticky", frame_err, 1'b1);
        frame_begin();
        check("t3_err_clr", frame_err, 1'b0);
        frame_end();

        // 4: abort after command, then a normal frame
        frame_begin();
        send_byte(8'h83);
        frame_end();
        check("t4_busy", busy, 1'b0);

        // 5: simultaneous decode + tx request
        frame_begin();
        both_cmd(8'h02);
        check("t5_bypass", data_to_send, 8'h12);
        need_byte(); check("t5_next", data_to_send, 8'h13);
        frame_end();

        // Random frames, with stray pulses between frames
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int nops;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) send_byte(8'($urandom));
                else need_byte();
            end
            cmd = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(8, 127))
                                              : 8'($urandom_range(0, N - 1));
            cmd[7] = 1'($urandom);
            frame_begin();
            if ($urandom_range(0, 3) == 0) begin
                both_cmd(cmd);
            end else begin
                if ($urandom_range(0, 1) == 0) need_byte();
                send_byte(cmd);
            end
            nops = $urandom_range(0, 10);
            for (int k = 0; k < nops; k++) begin
                if ($urandom_range(0, 1) == 0) send_byte(8'($urandom));
                else need_byte();
            end
            frame_end();
        end

        // 6: async reset in the middle of a write burst
        frame_begin();
        send_byte(8'h83);
        send_byte(8'h42);
        ssel = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6");
        check("t6_strobe", wr_strobe, 1'b0);
        check_regs("t6");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame_begin();
        send_byte(8'h85);
        send_byte(8'h3C);
        frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
